clk_phase_gen: RTL
==================

Name: clk_phase_gen

Overview:
Parametrised clock-phase generator and the successor to the fixed divide-by-2 clock scheme.
- Runs from the single board clock.
- Produces NUM_PHASES one-hot, single-cycle enable strobes per processor cycle: fetch, regfile, execute/dmem, writeback, and so on.
- Slot length is runtime-programmable.
- Supports run, halt and single-step modes for debug.
- Sits at top level beside the processor. Its strobes drive clock enables, replacing divided/inverted clocks.

Parameters:
NUM_PHASES, 4, phases per processor cycle; even, >=2
DIV_W, 4, width of div_ratio
START_RUNNING, 1, 1 = enter RUN after reset; 0 = enter HALTED after reset

Ports:
clock  in  1  master clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
div_ratio  in  DIV_W  clocks per phase slot (D); 0 is treated as 1
run  in  1  level; 1 = free-run
step  in  1  single-clock pulse; requests exactly one processor cycle while halted
phase_en  out  NUM_PHASES  one-hot strobe; bit p high for one clock at the end of slot p
phase_idx  out  clog2(NUM_PHASES)  index of the current slot
cycle_done  out  1  high with phase_en[NUM_PHASES-1]
div_clk  out  1  derived square wave; high for slots 0..NUM_PHASES/2-1
halted  out  1  1 while in HALTED

Behaviour:
Registers and outputs:
- State registers are mode (HALTED/RUN/STEP), slot counter cnt, phase_idx, and latched ratio D_l.
- All outputs are registered.

Reset:
- While reset=0, asynchronously: phase_en=0, cycle_done=0, div_clk=0, phase_idx=0, cnt=0.
- Also: D_l=max(div_ratio,1) sampled continuously; mode = RUN if START_RUNNING else HALTED; halted = !START_RUNNING.
- Asserting reset mid-cycle aborts that cycle immediately, with no clock needed.

Counting (RUN/STEP):
- cnt counts 0..D_l-1 within a slot.
- On the edge where cnt==D_l-1: cnt<=0, the registered phase_en[phase_idx]<=1 (all other bits 0), and phase_idx advances mod NUM_PHASES.
- On all other active edges phase_en<=0.
- cycle_done<=1 on the same edge as the phase_en[NUM_PHASES-1] strobe.
- Strobe spacing is exactly D_l clocks. The first strobe comes D_l edges after entering RUN/STEP with phase_idx=0.

div_clk:
- Registered each active edge to 1 when next phase_idx < NUM_PHASES/2, otherwise 0.
- Forced to 0 in HALTED.

div_ratio:
- Sampled into D_l only on the edge that completes slot NUM_PHASES-1, and on entry from HALTED.
- Mid-cycle changes never alter strobe spacing within the current processor cycle.

Mode FSM:
- HALTED -> RUN when run=1 (run wins if step=1 in the same clock).
- HALTED -> STEP when step=1 and run=0.
- RUN -> HALTED when run=0, only at the end-of-cycle edge. The current cycle always completes all NUM_PHASES strobes; a cycle is never truncated.
- STEP -> HALTED after exactly one full cycle, regardless of run. A run=1 seen during STEP is honoured on the following clock from HALTED.
- step is ignored in RUN and STEP.
- In HALTED, cnt and phase_idx hold 0, all strobes are 0, and halted=1. halted is registered and updates on the transition edge.

Invariants:
- phase_en is always one-hot or zero.
- phase_en and cycle_done are never high for more than one consecutive clock when D_l>1.
- When D_l=1, phase_en is continuous, rotating one-hot.

Decomposition:
- Shared package: mode encoding (MODE_HALTED, MODE_RUN, MODE_STEP) and a clog2 constant function.
- Natural sub-module: phase_slot_counter. It holds cnt, D_l and the ratio sampling, and outputs slot_end.
- The top-level module holds the mode FSM, phase_idx and the output registers.

Test Plan:
1. NUM_PHASES=4, div_ratio=1, START_RUNNING=1, release reset -> phase_en = 0001, 0010, 0100, 1000 after edges 1-4; cycle_done at edge 4; pattern repeats from edge 5; div_clk=1 after edges 4,1 (slots 0-1) and 0 after edges 2,3.
2. div_ratio=3 -> strobes at edges 3, 6, 9, 12; change div_ratio to 2 at edge 5 -> edges 6, 9, 12 unchanged, then strobes at 14, 16, 18, 20.
3. div_ratio=0 -> identical trace to scenario 1.
4. div_ratio=1, drop run after edge 2 -> 0100 at edge 3, 1000 plus cycle_done at edge 4, halted=1 after edge 4, no further strobes for 20 clocks.
5. While halted: step pulse -> exactly 4 strobes then halted=1. Step pulse during RUN -> no effect. run and step high together in HALTED -> enters RUN, continuous strobes.
6. div_ratio=2, assert reset between clock edges mid-slot 2 -> all outputs 0 before the next edge; after release, restart at phase 0 with first strobe 2 edges later.

Source files
------------

// File: rtl/clk_phase_gen_pkg.sv
// Shared definitions for the clock-phase generator: mode encoding and a
// constant-function log2 used to size the phase index.
package clk_phase_gen_pkg;

  typedef enum logic [1:0] {
    MODE_HALTED = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_STEP   = 2'd2
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/phase_slot_counter.sv
// Slot timer: counts clocks within one phase slot and holds the latched
// ratio, which only changes at processor-cycle boundaries.
module phase_slot_counter #(
  parameter int DIV_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             count_en,
  input  logic             load_ratio,
  output logic             slot_end
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ratio_l;
  logic [DIV_W-1:0] ratio_in;

  // A ratio of zero would never end a slot, so it behaves as one.
  assign ratio_in = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
  assign slot_end = count_en && (cnt == (ratio_l - DIV_W'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ratio_l <= ratio_in;
    end else begin
      if (!count_en || slot_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (load_ratio) begin
        ratio_l <= ratio_in;
      end
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// Clock-phase generator: one-hot per-slot enable strobes for the processor,
// with run / halt / single-step control.
module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int NUM_PHASES    = 4,
  parameter int DIV_W         = 4,
  parameter bit START_RUNNING = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DIV_W-1:0]               div_ratio,
  input  logic                           run,
  input  logic                           step,
  output logic [NUM_PHASES-1:0]          phase_en,
  output logic [clog2(NUM_PHASES)-1:0]   phase_idx,
  output logic                           cycle_done,
  output logic                           div_clk,
  output logic                           halted
);

  localparam int IDX_W = clog2(NUM_PHASES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NUM_PHASES / 2);

  mode_e            mode;
  logic             slot_end;
  logic             last_slot;
  logic             cycle_end;
  logic             enter;
  logic             load_ratio;
  logic             count_en;
  logic [IDX_W-1:0] next_idx;

  assign last_slot  = (phase_idx == LAST_IDX);
  assign cycle_end  = slot_end && last_slot;
  assign next_idx   = slot_end ? (last_slot ? '0 : phase_idx + IDX_W'(1)) : phase_idx;
  assign enter      = (mode == MODE_HALTED) && (run || step);
  assign load_ratio = enter || cycle_end;
  assign count_en   = (mode != MODE_HALTED);

  phase_slot_counter #(
    .DIV_W(DIV_W)
  ) u_slot (
    .clock      (clock),
    .reset      (reset),
    .div_ratio  (div_ratio),
    .count_en   (count_en),
    .load_ratio (load_ratio),
    .slot_end   (slot_end)
  );

  // div_clk follows the slot the generator will be in after this edge,
  // and is held low whenever that next mode is HALTED.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode       <= START_RUNNING ? MODE_RUN : MODE_HALTED;
      halted     <= !START_RUNNING;
      phase_idx  <= '0;
      phase_en   <= '0;
      cycle_done <= 1'b0;
      div_clk    <= 1'b0;
    end else begin
      phase_en   <= '0;
      cycle_done <= 1'b0;
      if (slot_end) begin
        phase_en[phase_idx] <= 1'b1;
        cycle_done          <= last_slot;
      end
      phase_idx <= next_idx;
      div_clk   <= (next_idx < HALF_IDX);
      case (mode)
        MODE_HALTED: begin
          phase_idx <= '0;
          if (run) begin
            mode   <= MODE_RUN;
            halted <= 1'b0;
          end else if (step) begin
            mode   <= MODE_STEP;
            halted <= 1'b0;
          end else begin
            div_clk <= 1'b0;
          end
        end
        MODE_RUN: begin
          if (cycle_end && !run) begin
            mode    <= MODE_HALTED;
            halted  <= 1'b1;
            div_clk <= 1'b0;
          end
        end
        MODE_STEP: begin
          if (cycle_end) begin
            mode    <= MODE_HALTED;
            halted  <= 1'b1;
            div_clk <= 1'b0;
          end
        end
        default: begin
          mode      <= MODE_HALTED;
          halted    <= 1'b1;
          div_clk   <= 1'b0;
          phase_idx <= '0;
        end
      endcase
    end
  end

endmodule
